// File: rtl/permutation_ctrl_pkg.sv
// Shared types and constants for the permutation round controller.
// Used by round_counter and permutation_ctrl.
package ascon_pack;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } type_perm_ctrl_state;

  localparam int NB_ROUNDS_A  = 12;
  localparam int NB_ROUNDS_B8 = 8;
  localparam int NB_ROUNDS_B6 = 6;
  localparam int LAST_ROUND   = 11;
  localparam int CNT_W        = 4;

  // A run of N rounds finishes on LAST_ROUND, so it begins at 12-N.
  function automatic logic [CNT_W-1:0] first_round(input logic [1:0] sel);
    case (sel)
      2'b01:   return CNT_W'(LAST_ROUND + 1 - NB_ROUNDS_B8);
      2'b10:   return CNT_W'(LAST_ROUND + 1 - NB_ROUNDS_B6);
      default: return CNT_W'(LAST_ROUND + 1 - NB_ROUNDS_A);
    endcase
  endfunction

endpackage

// File: rtl/permutation_ctrl_round_counter.sv
// Loadable, incrementing round index counter.
// Clear wins over load, load wins over increment.
module round_counter
  import ascon_pack::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock_i) begin
    if (reset_i || clear) count <= '0;
    else if (load)        count <= load_val;
    else if (inc)         count <= count + 1'b1;
  end

endmodule

// File: rtl/permutation_ctrl.sv
// Moore FSM sequencing the permutation round datapath (IDLE/FIRST/ROUND/DONE).
// Optional abort input enabled by defining PERM_CTRL_ABORT_EN.
module permutation_ctrl
  import ascon_pack::*;
#(
  parameter int ROUND_W = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [1:0]         rounds_sel_i,
  input  logic               xor_end_en_i,
  input  logic               xor_key_sel_i,
`ifdef PERM_CTRL_ABORT_EN
  input  logic               abort_i,
`endif
  output logic [ROUND_W-1:0] round_o,
  output logic               input_mode_o,
  output logic               enable_o,
  output logic               bypass_xor_end_o,
  output logic               mode_xor_key_o,
  output logic               busy_o,
  output logic               done_o
);

  type_perm_ctrl_state state, next_state;
  logic [CNT_W-1:0]    count;
  logic                xor_end_q, xor_key_q;
  logic                abort, active, at_last;
  logic                cnt_load, cnt_inc, cnt_clear;

`ifdef PERM_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign active  = (state == FIRST) || (state == ROUND);
  assign at_last = (count == CNT_W'(LAST_ROUND));

  // The counter holds 12-N from the start edge, so rounds_sel needs no register of its own.
  assign cnt_load  = (state == IDLE) && start_i;
  assign cnt_inc   = active && !abort && !at_last;
  assign cnt_clear = (active && abort) || (state == DONE);

  round_counter u_round_counter (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (first_round(rounds_sel_i)),
    .inc      (cnt_inc),
    .count    (count)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      xor_end_q <= 1'b0;
      xor_key_q <= 1'b0;
    end else if (cnt_load) begin
      xor_end_q <= xor_end_en_i;
      xor_key_q <= xor_key_sel_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_i) next_state = FIRST;
      FIRST,
      ROUND: begin
        if (abort)        next_state = IDLE;
        else if (at_last) next_state = DONE;
        else              next_state = ROUND;
      end
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    round_o          = '0;
    input_mode_o     = 1'b0;
    enable_o         = 1'b0;
    bypass_xor_end_o = 1'b1;
    mode_xor_key_o   = 1'b0;
    busy_o           = (state != IDLE);
    done_o           = (state == DONE);
    if (active) begin
      round_o        = ROUND_W'(count);
      input_mode_o   = (state == ROUND);
      enable_o       = 1'b1;
      mode_xor_key_o = xor_key_q;
      if (at_last) bypass_xor_end_o = !xor_end_q;
    end
  end

endmodule

// File: doc/permutation_ctrl.md
PERMUTATION_CTRL -- requirements
Module: permutation_ctrl

Interface
REQ-001 SHALL have parameter ROUND_W, default 4: width of round_o; legal values >= 4.
REQ-002 SHALL have port clock_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request one permutation run; sampled only in IDLE.
REQ-005 SHALL have port rounds_sel_i  input  2  run length: 00=12, 01=8, 10=6, 11=12.
REQ-006 SHALL have port xor_end_en_i  input  1  apply the end-of-permutation XOR on the last round.
REQ-007 SHALL have port xor_key_sel_i  input  1  key-XOR mode value for the last round.
REQ-008 SHALL have port round_o  output  ROUND_W  round-constant index for the round datapath.
REQ-009 SHALL have port input_mode_o  output  1  0 = load external state, 1 = loop the registered state.
REQ-010 SHALL have port enable_o  output  1  state-register load enable.
REQ-011 SHALL have port bypass_xor_end_o  output  1  1 = end XOR bypassed.
REQ-012 SHALL have port mode_xor_key_o  output  1  key-XOR mode sent to the datapath.
REQ-013 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse; the permutation result is valid in the datapath register.

Function
REQ-015 SHALL be a Moore FSM with states IDLE, FIRST, ROUND and DONE.
REQ-016 SHALL, in IDLE with start_i=1, latch rounds_sel_i, xor_end_en_i and xor_key_sel_i, load the round counter with 12-N (N = selected round count), and go to FIRST.
REQ-017 SHALL, in FIRST, drive enable_o=1, input_mode_o=0 and round_o=counter, then increment the counter and go to ROUND, or go to DONE when the counter equals 11.
REQ-018 SHALL, in ROUND, drive enable_o=1, input_mode_o=1 and round_o=counter, and increment the counter; it SHALL go to DONE when the counter equals 11.
REQ-019 SHALL drive bypass_xor_end_o = NOT latched xor_end_en only while round_o=11 with enable_o=1, and bypass_xor_end_o=1 at all other times.
REQ-020 SHALL drive mode_xor_key_o = latched xor_key_sel in FIRST and ROUND, and 0 elsewhere.
REQ-021 SHALL, in DONE, drive done_o=1 and enable_o=0, then go to IDLE unconditionally.
REQ-022 SHALL assert done_o exactly N+1 cycles after the clock edge that sampled start_i (13, 9 or 7 cycles).
REQ-023 SHALL ignore start_i in FIRST, ROUND and DONE; a start held high across DONE SHALL be accepted in the following IDLE cycle.
REQ-024 SHALL never let the round counter exceed 11 or wrap.
REQ-025 SHALL, in IDLE and DONE, drive round_o=0, input_mode_o=0 and enable_o=0.

Reset
REQ-026 SHALL, on reset_i=1 at a clock edge, go to IDLE and clear the counter and all latched configuration, including in the middle of a run; no done_o SHALL follow an interrupted run.
REQ-027 SHALL give these output values during and after reset: round_o=0, input_mode_o=0, enable_o=0, bypass_xor_end_o=1, mode_xor_key_o=0, busy_o=0, done_o=0.

Configuration
REQ-028 SHALL, with PERM_CTRL_ABORT_EN defined, add input abort_i (1 bit); abort_i=1 in FIRST or ROUND SHALL force IDLE at the next edge with enable_o=0 and no done_o, and abort_i SHALL have no effect in IDLE or DONE.
REQ-029 SHALL, without PERM_CTRL_ABORT_EN, have no abort_i port, and its behaviour SHALL be identical to an abort_i tied to 0.

Structure
REQ-030 SHALL declare the following in ascon_pack: the state enum type_perm_ctrl_state, the constants NB_ROUNDS_A=12, NB_ROUNDS_B8=8, NB_ROUNDS_B6=6, and LAST_ROUND=11.
REQ-031 SHALL place the loadable, incrementing round counter in a sub-module named round_counter, with the FSM in permutation_ctrl.
REQ-032 SHALL connect directly to the permutation datapath round, input-mode, enable, bypass and key-mode inputs without glue logic.

Verification
REQ-033 SHALL cover: rounds_sel=00, start pulse -> round_o 0..11 on consecutive cycles, input_mode_o=0 only on round 0, done_o 13 cycles after start, a single pulse.
REQ-034 SHALL cover: rounds_sel=10, xor_end_en=1, xor_key_sel=1 -> round_o 6..11, bypass_xor_end_o=0 and mode_xor_key_o=1 exactly on round 11, done_o after 7 cycles.
REQ-035 SHALL cover: rounds_sel=01 with start_i held high for 20 cycles -> round_o 4..11, done_o at cycle 9, a second run starting at cycle 10 with no overlap.
REQ-036 SHALL cover: reset_i=1 while round_o=5 -> next cycle all outputs at reset values, no done_o, and a new start runs normally.
REQ-037 SHALL cover: rounds_sel=11 -> behaviour identical to 00; start_i toggled during a run -> ignored.
REQ-038 SHALL cover, with PERM_CTRL_ABORT_EN: abort_i=1 at round_o=3 -> IDLE next cycle, enable_o=0, busy_o=0, no done_o.
